uart_tx_buffered: RTL and testbench

Buffered UART transmitter: the sending end matching the UART checker's receive path. The test sequencer preloads a byte buffer, pulses a start request, and the block serializes N consecutive bytes back-to-back on `o_tx` with the configured framing. It sits on the DUT side of the bench loop; its `o_tx` drives the checker's `i_rx` so `RX_READ` can compare the received bytes.

---
 rtl/uart_tx_buffered.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: sends buffer words 0..N-1 back-to-back on o_tx
// with configurable data width, parity, stop bits, bit order and line polarity.
module uart_tx_buffered #(
    parameter int G_CLOCK_FREQ        = 20000000,
    parameter int G_BAUDRATE          = 115200,
    parameter int G_DATA_WIDTH        = 8,
    parameter int G_PARITY            = 0,
    parameter int G_STOP_BIT_NUMBER   = 1,
    parameter int G_FIRST_BIT         = 0,
    parameter int G_POLARITY          = 1,
    parameter int G_BUFFER_ADDR_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_wr_en,
    input  logic [G_BUFFER_ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [G_DATA_WIDTH-1:0]        i_wr_data,
    input  logic                           i_start,
    input  logic [G_BUFFER_ADDR_WIDTH:0]   i_nb_data,
    output logic                           o_tx,
    output logic                           o_busy,
    output logic                           o_done
);

    // state    | meaning
    // S_IDLE   | line idle, waiting for a start request with a nonzero count
    // S_START  | start bit of the current frame
    // S_DATA   | data bits, shifted out in the configured order
    // S_PARITY | parity bit (skipped when parity is disabled)
    // S_STOP   | stop bit(s); then next frame or back to idle

    localparam int DIV    = G_CLOCK_FREQ / G_BAUDRATE;
    localparam int AW     = G_BUFFER_ADDR_WIDTH;
    localparam int DW     = G_DATA_WIDTH;
    localparam int BAUD_W = $clog2(DIV);
    localparam int BIT_W  = 4;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DW - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(G_STOP_BIT_NUMBER - 1);
    localparam logic              HAS_PARITY = (G_PARITY != 0);
    localparam logic              ODD_PARITY = (G_PARITY == 2);
    localparam logic              MSB_FIRST  = (G_FIRST_BIT != 0);
    localparam logic              LINE_INV   = (G_POLARITY == 0);
    localparam logic              IDLE_LVL   = !LINE_INV;
    localparam logic              START_LVL  = LINE_INV;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DW-1:0]     shift_q, shift_d;
    logic              parity_q, parity_d;
    logic [AW:0]       ptr_q, ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DW-1:0]     buffer_mem [0:(2**AW)-1];
    logic [DW-1:0]     rd_data;
    logic              bit_end;

    function automatic logic line_lvl(input logic b);
        return b ^ LINE_INV;
    endfunction

    function automatic logic first_bit(input logic [DW-1:0] v);
        return MSB_FIRST ? v[DW-1] : v[0];
    endfunction

    function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] v);
        return MSB_FIRST ? {v[DW-2:0], 1'b0} : {1'b0, v[DW-1:1]};
    endfunction

    function automatic logic calc_parity(input logic [DW-1:0] v);
        return (^v) ^ ODD_PARITY;
    endfunction

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            buffer_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // ptr_q is held at 0 while idle, so this also fetches word 0 for the first frame
    assign rd_data = buffer_mem[ptr_q[AW-1:0]];
    assign bit_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            ptr_q    <= '0;
            count_q  <= '0;
            tx_q     <= IDLE_LVL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            ptr_q    <= ptr_d;
            count_q  <= count_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        ptr_d    = ptr_q;
        count_d  = count_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d   = IDLE_LVL;
                busy_d = 1'b0;
                baud_d = '0;
                bit_d  = '0;
                ptr_d  = '0;
                if (i_start && (i_nb_data != '0)) begin
                    state_d  = S_START;
                    count_d  = i_nb_data;
                    shift_d  = rd_data;
                    parity_d = calc_parity(rd_data);
                    ptr_d    = (AW + 1)'(1);
                    tx_d     = START_LVL;
                    busy_d   = 1'b1;
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = line_lvl(first_bit(shift_q));
                    shift_d = shift_out(shift_q);
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (HAS_PARITY) begin
                            state_d = S_PARITY;
                            tx_d    = line_lvl(parity_q);
                        end else begin
                            state_d = S_STOP;
                            tx_d    = IDLE_LVL;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = line_lvl(first_bit(shift_q));
                        shift_d = shift_out(shift_q);
                    end
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    tx_d    = IDLE_LVL;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    bit_d = '0;
                    if (bit_q != STOP_LAST) begin
                        bit_d = bit_q + 1'b1;
                    end else if (ptr_q != count_q) begin
                        // next word follows immediately, no idle gap
                        state_d  = S_START;
                        shift_d  = rd_data;
                        parity_d = calc_parity(rd_data);
                        ptr_d    = ptr_q + 1'b1;
                        tx_d     = START_LVL;
                    end else begin
                        state_d = S_IDLE;
                        ptr_d   = '0;
                        tx_d    = IDLE_LVL;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                tx_d    = IDLE_LVL;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign o_tx   = tx_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: three framing configurations, a line
// decoder feeding a scoreboard of expected words, and busy/done timing checks.
module tb_uart_tx_buffered;

    localparam int DIV  = 10;
    localparam int TLIM = 600000;

    localparam int C_DW[3]    = '{8, 8, 5};
    localparam int C_PAR[3]   = '{0, 1, 2};
    localparam int C_STOP[3]  = '{1, 2, 1};
    localparam int C_FIRST[3] = '{0, 1, 0};
    localparam int C_POL[3]   = '{1, 0, 1};
    localparam int C_AW[3]    = '{4, 3, 2};
    localparam int C_D0[3]    = '{'h55, 'h07, 'h07};
    localparam int C_D1[3]    = '{'hFF, 'h80, 'h15};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int DW    = C_DW[g];
        localparam int PAR   = C_PAR[g];
        localparam int STOPB = C_STOP[g];
        localparam int FIRST = C_FIRST[g];
        localparam int POL   = C_POL[g];
        localparam int AW    = C_AW[g];
        localparam int DEPTH = 2 ** AW;
        localparam int FL    = 1 + DW + ((PAR != 0) ? 1 : 0) + STOPB;
        localparam int FLC   = FL * DIV;
        localparam logic IDLE_LINE  = (POL != 0);
        localparam logic START_LINE = (POL == 0);

        logic          rst_n   = 1'b0;
        logic          wr_en   = 1'b0;
        logic [AW-1:0] wr_addr = '0;
        logic [DW-1:0] wr_data = '0;
        logic          start   = 1'b0;
        logic [AW:0]   nb      = '0;
        logic          tx, busy, done;
        bit            fin     = 1'b0;

        logic [DW-1:0] mem_m [DEPTH];
        logic [DW-1:0] exp_q [$];

        uart_tx_buffered #(
            .G_CLOCK_FREQ       (20000000),
            .G_BAUDRATE         (2000000),
            .G_DATA_WIDTH       (DW),
            .G_PARITY           (PAR),
            .G_STOP_BIT_NUMBER  (STOPB),
            .G_FIRST_BIT        (FIRST),
            .G_POLARITY         (POL),
            .G_BUFFER_ADDR_WIDTH(AW)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_wr_en  (wr_en),
            .i_wr_addr(wr_addr),
            .i_wr_data(wr_data),
            .i_start  (start),
            .i_nb_data(nb),
            .o_tx     (tx),
            .o_busy   (busy),
            .o_done   (done)
        );

        task automatic wr(input int a, input int v);
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = AW'(a);
            wr_data = DW'(v);
            mem_m[a] = DW'(v);
            @(negedge clk);
            wr_en = 1'b0;
        endtask

        // One transfer of n words; optional ignored start, mid-transfer write, or reset.
        task automatic run(input int n, input int ign_at, input int wr_at,
                           input int wa, input int wv, input int rst_at);
            int len, busy_n, done_n, done_k, idle_err;
            len = n * FLC;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back((wr_at >= 0 && wa == i && wr_at + 1 < i * FLC) ? DW'(wv) : mem_m[i]);
            end
            @(negedge clk);
            start = 1'b1;
            nb    = (AW + 1)'(n);
            @(negedge clk);
            start = 1'b0;
            busy_n = 0; done_n = 0; done_k = -1; idle_err = 0;
            for (int k = 0; k <= len + 2 * DIV; k++) begin
                start = (k == ign_at);
                if (k == ign_at) nb = (AW + 1)'($urandom_range(1, DEPTH));
                if (k == wr_at) begin
                    wr_en   = 1'b1;
                    wr_addr = AW'(wa);
                    wr_data = DW'(wv);
                    mem_m[wa] = DW'(wv);
                end else begin
                    wr_en = 1'b0;
                end
                if (k == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    check($sformatf("u%0d tx at async reset", g), tx, IDLE_LINE);
                    check($sformatf("u%0d busy at async reset", g), busy, 0);
                    check($sformatf("u%0d done at async reset", g), done, 0);
                    exp_q.delete();
                end
                if (rst_at >= 0 && k == rst_at + 3) rst_n = 1'b1;
                if (busy) busy_n++;
                if (done) begin
                    done_n++;
                    done_k = k;
                end
                if (k >= len && tx !== IDLE_LINE) idle_err++;
                @(negedge clk);
            end
            if (rst_at < 0) begin
                check($sformatf("u%0d busy cycles n=%0d", g, n), busy_n, len);
                check($sformatf("u%0d done count n=%0d", g, n), done_n, 1);
                check($sformatf("u%0d done position n=%0d", g, n), done_k, len);
            end else begin
                check($sformatf("u%0d busy cycles before reset", g), busy_n, rst_at);
                check($sformatf("u%0d done count with reset", g), done_n, 0);
            end
            check($sformatf("u%0d tx idle after transfer", g), idle_err, 0);
        endtask

        // Line decoder: samples each bit mid-period and scores whole frames.
        initial begin : mon
            int pos, k;
            bit in_fr;
            logic [FL-1:0] bits, ef;
            logic [DW-1:0] e;
            pos = 0; in_fr = 1'b0; bits = '0;
            forever begin
                @(posedge clk);
                #1;
                if (!rst_n) begin
                    in_fr = 1'b0;
                    pos   = 0;
                end else begin
                    if (!in_fr && tx === START_LINE) begin
                        in_fr = 1'b1;
                        pos   = 0;
                    end
                    if (in_fr) begin
                        if (pos % DIV == DIV / 2) bits[pos / DIV] = (tx === IDLE_LINE);
                        pos++;
                        if (pos == FLC) begin
                            in_fr = 1'b0;
                            check($sformatf("u%0d frame was expected", g), 64'(exp_q.size() != 0), 1);
                            if (exp_q.size() != 0) begin
                                e  = exp_q.pop_front();
                                ef = '0;
                                for (int i = 0; i < DW; i++) ef[1 + i] = (FIRST != 0) ? e[DW - 1 - i] : e[i];
                                k = 1 + DW;
                                if (PAR != 0) begin
                                    ef[k] = (^e) ^ (PAR == 2);
                                    k++;
                                end
                                for (int s = 0; s < STOPB; s++) ef[k + s] = 1'b1;
                                check($sformatf("u%0d frame bits for word 0x%0h", g, e), 64'(bits), 64'(ef));
                            end
                        end
                    end
                end
            end
        end

        initial begin : stim
            int n, b_cnt, d_cnt, t_cnt;
            repeat (3) @(negedge clk);
            check($sformatf("u%0d tx in reset", g), tx, IDLE_LINE);
            check($sformatf("u%0d busy in reset", g), busy, 0);
            check($sformatf("u%0d done in reset", g), done, 0);
            rst_n = 1'b1;
            @(negedge clk);
            check($sformatf("u%0d tx after reset", g), tx, IDLE_LINE);
            check($sformatf("u%0d busy after reset", g), busy, 0);

            start = 1'b1;
            nb    = '0;
            @(negedge clk);
            start = 1'b0;
            b_cnt = 0; d_cnt = 0; t_cnt = 0;
            for (int k = 0; k < 3 * DIV; k++) begin
                if (busy) b_cnt++;
                if (done) d_cnt++;
                if (tx !== IDLE_LINE) t_cnt++;
                @(negedge clk);
            end
            check($sformatf("u%0d zero count busy", g), b_cnt, 0);
            check($sformatf("u%0d zero count done", g), d_cnt, 0);
            check($sformatf("u%0d zero count tx", g), t_cnt, 0);

            wr(0, C_D0[g]);
            run(1, -1, -1, 0, 0, -1);
            wr(0, C_D1[g]);
            run(1, -1, -1, 0, 0, -1);

            wr(0, 'hFF); wr(1, 'h01); wr(2, 'hDD); wr(3, 'hCA);
            run(4, 2 * FLC + 5, -1, 0, 0, -1);

            for (int a = 0; a < DEPTH; a++) wr(a, int'($urandom));
            run(DEPTH, -1, -1, 0, 0, -1);

            repeat (3) begin
                n = $urandom_range(1, DEPTH);
                for (int a = 0; a < n; a++) wr(a, int'($urandom));
                run(n, -1, -1, 0, 0, -1);
            end

            for (int a = 0; a < 3; a++) wr(a, int'($urandom));
            run(3, -1, 3 * DIV, 2, 'h3C, -1);

            for (int a = 0; a < 3; a++) wr(a, int'($urandom));
            run(3, -1, -1, 0, 0, FLC + 4 * DIV + 3);
            check($sformatf("u%0d tx after mid-frame reset", g), tx, IDLE_LINE);
            check($sformatf("u%0d busy after mid-frame reset", g), busy, 0);

            for (int a = 0; a < 2; a++) wr(a, int'($urandom));
            run(2, -1, -1, 0, 0, -1);

            check($sformatf("u%0d words left in scoreboard", g), exp_q.size(), 0);
            fin = 1'b1;
        end
    end

    initial begin
        fork
            wait (u[0].fin && u[1].fin && u[2].fin);
            #(TLIM);
        join_any
        disable fork;
        check("all configurations finished", {63'b0, u[0].fin & u[1].fin & u[2].fin}, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
